pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Decodes the ID-stage opcode into WB/M/EX control bundles and carries them in
//  registered ID/EX, EX/MEM and MEM/WB control stages. Supports stall (bubble
//  insert) and flush, and counts inserted bubbles. Sits beside the datapath
//  pipeline registers; each stage output drives that stage's datapath controls.
// PARAMETERS
//  OPW   6   opcode width; opcode compared zero-extended to OPW
//  WBW   2   WB bundle width; table values zero-extended when wider
//  MW    3   M bundle width; same extension rule
//  EXW   8   EX bundle width; same extension rule
//  CNTW  16  bubble counter width
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  id_valid     in   1     opcode is a live instruction this cycle
//  opcode       in   OPW   ID-stage opcode
//  stall        in   1     hold decode; load bubble into ID/EX
//  flush        in   1     kill ID/EX and EX/MEM contents
//  id_ex_wb     out  WBW   ID/EX WB bundle
//  id_ex_m      out  MW    ID/EX M bundle
//  id_ex_ex     out  EXW   ID/EX EX bundle
//  ex_mem_wb    out  WBW   EX/MEM WB bundle
//  ex_mem_m     out  MW    EX/MEM M bundle
//  mem_wb_wb    out  WBW   MEM/WB WB bundle
//  stage_valid  out  3     {mem_wb, ex_mem, id_ex} valid bits
//  bubble_cnt   out  CNTW  bubbles inserted since reset, saturating
// BEHAVIOUR
//  Decode (combinational, opcode -> WB,M,EX); any other opcode -> all zero:
//   100100 11,010,01001001 | 100101 00,001,01001011 | 000001 10,000,10000010
//   000011 10,000,10000110 | 000101 10,000,10001010 | 000110 10,000,10001100
//   100000 10,000,01000001 | 100001 10,000,01000011 | 101000 00,100,01010000
//   101001 00,100,01010010 | 101010 00,100,01010100
//  Reset: all bundle outputs, stage_valid, bubble_cnt = 0, immediately (async).
//  Each posedge, priority flush > stall > normal:
//   normal: ID/EX <= decode if id_valid else zero (valid=id_valid);
//           EX/MEM <= ID/EX {wb,m}; MEM/WB <= EX/MEM wb; valids shift.
//   stall:  ID/EX <= zero, valid 0; EX/MEM, MEM/WB advance as normal.
//   flush:  ID/EX and EX/MEM <= zero, valids 0; MEM/WB <= EX/MEM prior value.
//  Latency: decode visible on id_ex_* 1 cycle after capture, ex_mem_* 2,
//   mem_wb_wb 3. Invalid stage always holds all-zero bundles.
//  bubble_cnt: +1 per cycle with stall=1 and flush=0 and id_valid=1;
//   flush adds nothing; saturates at all-ones, no wrap.
//  stall+flush same cycle: flush wins, counter unchanged.
//  Reset mid-operation: all stages cleared at once; no partial drain.
// CONFIGURATION
//  ILLEGAL_OPCODE_TRAP_EN defined: extra port illegal_op (out, 1), sticky;
//   set on a posedge capturing id_valid=1, stall=0, flush=0 with opcode not in
//   table; cleared only by rst. Captured illegal opcode enters ID/EX as bubble
//   (valid 0).
//  Undefined: no port; unknown opcode enters ID/EX as valid, all-zero bundle.
// TESTING
//  T1 rst pulse mid-stream -> all outputs 0 same cycle, stay 0 until new input.
//  T2 id_valid=1, opcode 100100 -> cycle1 id_ex=11/010/01001001, cycle2
//     ex_mem=11/010, cycle3 mem_wb_wb=11, stage_valid 001->011->111.
//  T3 stream 000001,100101,101000 with stall on 2nd cycle -> bubble between
//     1st and 3rd in all stages; bubble_cnt=1; 100101 not issued.
//  T4 flush while 100100 in ID/EX, 000011 in EX/MEM -> both zeroed, mem_wb_wb
//     =10 from 000011's predecessor path; stall+flush same cycle -> cnt unchanged.
//  T5 CNTW=2, stall 5 cycles -> bubble_cnt 1,2,3,3,3.
//  T6 opcode 111111 -> with ILLEGAL_OPCODE_TRAP_EN illegal_op=1 sticky,
//     stage_valid[0]=0; without, stage_valid[0]=1 with zero bundles.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//
// Purpose:
//   Decodes the ID-stage opcode into WB/M/EX control bundles. The bundles are
//   carried through registered ID/EX, EX/MEM and MEM/WB control stages that
//   sit beside the datapath pipeline registers. Each stage output drives the
//   datapath controls of that stage.
//   Stall replaces the decode with a bubble in ID/EX while the older stages
//   keep draining. Flush kills ID/EX and EX/MEM.
//   Inserted bubbles are counted in a saturating counter.
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst          in   1     asynchronous, active-high reset
//   id_valid     in   1     opcode is a live instruction this cycle
//   opcode       in   OPW   ID-stage opcode
//   stall        in   1     hold decode; load bubble into ID/EX
//   flush        in   1     kill ID/EX and EX/MEM contents
//   id_ex_wb     out  WBW   ID/EX WB bundle
//   id_ex_m      out  MW    ID/EX M bundle
//   id_ex_ex     out  EXW   ID/EX EX bundle
//   ex_mem_wb    out  WBW   EX/MEM WB bundle
//   ex_mem_m     out  MW    EX/MEM M bundle
//   mem_wb_wb    out  WBW   MEM/WB WB bundle
//   stage_valid  out  3     {mem_wb, ex_mem, id_ex} valid bits
//   bubble_cnt   out  CNTW  bubbles inserted since reset, saturating
//   illegal_op   out  1     sticky unknown-opcode flag. This port exists only
//                           when ILLEGAL_OPCODE_TRAP_EN is defined.
//
// Configuration macro:
//   ILLEGAL_OPCODE_TRAP_EN
//     Undefined (default): an unknown opcode issues into ID/EX as valid, with
//       all-zero bundles.
//     Defined: an unknown opcode issues as a bubble and sets illegal_op.
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter int OPW  = 6,
    parameter int WBW  = 2,
    parameter int MW   = 3,
    parameter int EXW  = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [OPW-1:0]  opcode,
    input  logic            stall,
    input  logic            flush,
    output logic [WBW-1:0]  id_ex_wb,
    output logic [MW-1:0]   id_ex_m,
    output logic [EXW-1:0]  id_ex_ex,
    output logic [WBW-1:0]  ex_mem_wb,
    output logic [MW-1:0]   ex_mem_m,
    output logic [WBW-1:0]  mem_wb_wb,
    output logic [2:0]      stage_valid,
    output logic [CNTW-1:0] bubble_cnt
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    // Native table bundle: {wb[1:0], m[2:0], ex[7:0]}. An all-zero result
    // means the opcode is not in the table, because every table entry is
    // non-zero.
    function automatic logic [12:0] decode(input logic [OPW-1:0] op);
        logic [12:0] r;
        r = '0;
        case (op)
            OPW'(6'b100100): r = {2'b11, 3'b010, 8'b01001001};
            OPW'(6'b100101): r = {2'b00, 3'b001, 8'b01001011};
            OPW'(6'b000001): r = {2'b10, 3'b000, 8'b10000010};
            OPW'(6'b000011): r = {2'b10, 3'b000, 8'b10000110};
            OPW'(6'b000101): r = {2'b10, 3'b000, 8'b10001010};
            OPW'(6'b000110): r = {2'b10, 3'b000, 8'b10001100};
            OPW'(6'b100000): r = {2'b10, 3'b000, 8'b01000001};
            OPW'(6'b100001): r = {2'b10, 3'b000, 8'b01000011};
            OPW'(6'b101000): r = {2'b00, 3'b100, 8'b01010000};
            OPW'(6'b101001): r = {2'b00, 3'b100, 8'b01010010};
            OPW'(6'b101010): r = {2'b00, 3'b100, 8'b01010100};
            default:         r = '0;
        endcase
        return r;
    endfunction

    logic [12:0]     dec;
    logic [WBW-1:0]  dec_wb;
    logic [MW-1:0]   dec_m;
    logic [EXW-1:0]  dec_ex;
    logic            op_legal;
    logic            issue;

    logic [WBW-1:0]  id_ex_wb_q,  id_ex_wb_d;
    logic [MW-1:0]   id_ex_m_q,   id_ex_m_d;
    logic [EXW-1:0]  id_ex_ex_q,  id_ex_ex_d;
    logic [WBW-1:0]  ex_mem_wb_q, ex_mem_wb_d;
    logic [MW-1:0]   ex_mem_m_q,  ex_mem_m_d;
    logic [WBW-1:0]  mem_wb_wb_q, mem_wb_wb_d;
    logic [2:0]      stage_vld_q, stage_vld_d;
    logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;
    logic            illegal_q,   illegal_d;

    // Table values are zero-extended when a bundle is wider than its table
    // entry.
    assign dec      = decode(opcode);
    assign dec_wb   = WBW'(dec[12:11]);
    assign dec_m    = MW'(dec[10:8]);
    assign dec_ex   = EXW'(dec[7:0]);
    assign op_legal = |dec;

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign issue = id_valid & op_legal;
`else
    assign issue = id_valid;
`endif

    always_comb begin
        // The older stages advance by default. ID/EX loads a bubble unless an
        // instruction issues.
        id_ex_wb_d   = '0;
        id_ex_m_d    = '0;
        id_ex_ex_d   = '0;
        ex_mem_wb_d  = id_ex_wb_q;
        ex_mem_m_d   = id_ex_m_q;
        mem_wb_wb_d  = ex_mem_wb_q;
        stage_vld_d  = {stage_vld_q[1:0], 1'b0};
        bubble_cnt_d = bubble_cnt_q;
        illegal_d    = illegal_q;

        if (flush) begin
            // MEM/WB still takes the old EX/MEM contents. Only the two
            // younger stages are killed.
            ex_mem_wb_d    = '0;
            ex_mem_m_d     = '0;
            stage_vld_d[1] = 1'b0;
        end else if (stall) begin
            // A bubble counts only when it displaces a live instruction.
            if (id_valid && (bubble_cnt_q != {CNTW{1'b1}})) begin
                bubble_cnt_d = bubble_cnt_q + CNTW'(1);
            end
        end else begin
            if (issue) begin
                id_ex_wb_d     = dec_wb;
                id_ex_m_d      = dec_m;
                id_ex_ex_d     = dec_ex;
                stage_vld_d[0] = 1'b1;
            end
            if (id_valid && !op_legal) begin
                illegal_d = 1'b1;
            end
        end
    end

    // ---- ID/EX, EX/MEM, MEM/WB stage registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_wb_q   <= '0;
            id_ex_m_q    <= '0;
            id_ex_ex_q   <= '0;
            ex_mem_wb_q  <= '0;
            ex_mem_m_q   <= '0;
            mem_wb_wb_q  <= '0;
            stage_vld_q  <= '0;
            bubble_cnt_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            id_ex_wb_q   <= id_ex_wb_d;
            id_ex_m_q    <= id_ex_m_d;
            id_ex_ex_q   <= id_ex_ex_d;
            ex_mem_wb_q  <= ex_mem_wb_d;
            ex_mem_m_q   <= ex_mem_m_d;
            mem_wb_wb_q  <= mem_wb_wb_d;
            stage_vld_q  <= stage_vld_d;
            bubble_cnt_q <= bubble_cnt_d;
            illegal_q    <= illegal_d;
        end
    end

    assign id_ex_wb    = id_ex_wb_q;
    assign id_ex_m     = id_ex_m_q;
    assign id_ex_ex    = id_ex_ex_q;
    assign ex_mem_wb   = ex_mem_wb_q;
    assign ex_mem_m    = ex_mem_m_q;
    assign mem_wb_wb   = mem_wb_wb_q;
    assign stage_valid = stage_vld_q;
    assign bubble_cnt  = bubble_cnt_q;

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign illegal_op = illegal_q;
`else
    // Without the trap the sticky flag has no consumer.
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
//
// Self-checking bench for pipelined_control_unit.
//
// Instances:
//   dut   default parameters
//   dut2  CNTW=2, used for the saturating bubble counter
//
// Reference model:
//   Each pipeline stage is kept as a {valid, wb, m, ex} record.
//   The records are moved according to the flush > stall > normal rules.
//   Bundles come from the opcode table by lookup.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  opcode;
    logic        stall;
    logic        flush;
    logic [1:0]  id_ex_wb, ex_mem_wb, mem_wb_wb;
    logic [2:0]  id_ex_m, ex_mem_m;
    logic [7:0]  id_ex_ex;
    logic [2:0]  stage_valid;
    logic [15:0] bubble_cnt;
    logic        ill;

    logic [1:0]  d2_id_ex_wb, d2_ex_mem_wb, d2_mem_wb_wb;
    logic [2:0]  d2_id_ex_m, d2_ex_mem_m;
    logic [7:0]  d2_id_ex_ex;
    logic [2:0]  d2_stage_valid;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
        .stall(stall), .flush(flush),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .mem_wb_wb(mem_wb_wb),
        .stage_valid(stage_valid), .bubble_cnt(bubble_cnt)
`ifdef ILLEGAL_OPCODE_TRAP_EN
        , .illegal_op(ill)
`endif
    );

    pipelined_control_unit #(.CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
        .stall(stall), .flush(flush),
        .id_ex_wb(d2_id_ex_wb), .id_ex_m(d2_id_ex_m), .id_ex_ex(d2_id_ex_ex),
        .ex_mem_wb(d2_ex_mem_wb), .ex_mem_m(d2_ex_mem_m), .mem_wb_wb(d2_mem_wb_wb),
        .stage_valid(d2_stage_valid), .bubble_cnt(cnt2)
`ifdef ILLEGAL_OPCODE_TRAP_EN
        , .illegal_op()
`endif
    );

`ifndef ILLEGAL_OPCODE_TRAP_EN
    assign ill = 1'b0;
`endif

    // ---------------- reference model ----------------
    bit         m_v  [3];
    logic [1:0] m_wb [3];
    logic [2:0] m_m  [2];
    logic [7:0] m_ex;
    int         m_cnt, m_cnt2;
    bit         m_ill;

    function automatic logic [12:0] ref_decode(input logic [5:0] op);
        logic [18:0] tbl [11];
        tbl = '{ {6'b100100, 13'b11_010_01001001}, {6'b100101, 13'b00_001_01001011},
                 {6'b000001, 13'b10_000_10000010}, {6'b000011, 13'b10_000_10000110},
                 {6'b000101, 13'b10_000_10001010}, {6'b000110, 13'b10_000_10001100},
                 {6'b100000, 13'b10_000_01000001}, {6'b100001, 13'b10_000_01000011},
                 {6'b101000, 13'b00_100_01010000}, {6'b101001, 13'b00_100_01010010},
                 {6'b101010, 13'b00_100_01010100} };
        for (int i = 0; i < 11; i++)
            if (tbl[i][18:13] == op) return tbl[i][12:0];
        return 13'd0;
    endfunction

    function automatic bit in_table(input logic [5:0] op);
        return ref_decode(op) != 13'd0;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_wb[i] = '0; end
        m_m[0] = '0; m_m[1] = '0; m_ex = '0;
        m_cnt = 0; m_cnt2 = 0; m_ill = 0;
    endtask

    task automatic mdl_clock(input bit iv, input logic [5:0] op, input bit st, input bit fl);
        logic [12:0] d;
        bit issue;
        d = ref_decode(op);
        // MEM/WB always takes what EX/MEM held.
        m_v[2] = m_v[1]; m_wb[2] = m_wb[1];
        if (fl) begin
            m_v[1] = 0; m_wb[1] = '0; m_m[1] = '0;
            m_v[0] = 0; m_wb[0] = '0; m_m[0] = '0; m_ex = '0;
        end else begin
            m_v[1] = m_v[0]; m_wb[1] = m_wb[0]; m_m[1] = m_m[0];
            issue = 0;
            if (st) begin
                if (iv) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else begin
                if (iv && !in_table(op)) m_ill = 1;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                issue = iv && in_table(op);
`else
                issue = iv;
`endif
            end
            m_v[0]  = issue;
            m_wb[0] = issue ? d[12:11] : 2'b00;
            m_m[0]  = issue ? d[10:8]  : 3'b000;
            m_ex    = issue ? d[7:0]   : 8'h00;
        end
    endtask

    function automatic logic [41:0] mdl_vec();
        logic ie;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ie = m_ill;
`else
        ie = 1'b0;
`endif
        return {m_wb[0], m_m[0], m_ex, m_wb[1], m_m[1], m_wb[2],
                m_v[2], m_v[1], m_v[0], 16'(m_cnt), 2'(m_cnt2), ie};
    endfunction

    logic [41:0] dut_vec;
    assign dut_vec = {id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb,
                      stage_valid, bubble_cnt, cnt2, ill};

    // Drives one cycle of inputs just after an edge, waits for the next edge,
    // advances the model, then settles 1 time unit past the edge.
    task automatic step(input bit iv, input logic [5:0] op, input bit st, input bit fl);
        id_valid = iv; opcode = op; stall = st; flush = fl;
        @(posedge clk);
        mdl_clock(iv, op, st, fl);
        #1;
    endtask

    task automatic do_reset();
        id_valid = 0; opcode = '0; stall = 0; flush = 0;
        rst = 1'b1;
        #1;
        mdl_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) step(1, 6'b100100, 0, 0);
        // Assert reset between edges; the outputs must clear without a clock.
        rst = 1'b1;
        #1;
        mdl_reset();
        checks++;
        if (dut_vec !== 42'd0) begin
            errors++; $display("FAIL reset_async: got %h expected %h", dut_vec, 42'd0);
        end
        id_valid = 1; opcode = 6'b000001;
        @(posedge clk); #1;
        checks++;
        if (dut_vec !== 42'd0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec, 42'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(0, 6'b000001, 0, 0);
            checks++;
            if (dut_vec !== mdl_vec()) begin
                errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec, mdl_vec());
            end
        end
    endtask

    task automatic test_latency();
        logic [2:0] exp_sv [3];
        exp_sv = '{3'b001, 3'b011, 3'b111};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 6'b100100, 0, 0);
            checks++;
            if (stage_valid !== exp_sv[i]) begin
                errors++; $display("FAIL latency_valid%0d: got %b expected %b", i, stage_valid, exp_sv[i]);
            end
            checks++;
            if (dut_vec !== mdl_vec()) begin
                errors++; $display("FAIL latency_vec%0d: got %h expected %h", i, dut_vec, mdl_vec());
            end
        end
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb} !==
            {2'b11, 3'b010, 8'b01001001, 2'b11, 3'b010, 2'b11}) begin
            errors++; $display("FAIL latency_bundles: got %b/%b/%b %b/%b %b expected 11/010/01001001 11/010 11",
                               id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1, 6'b000001, 0, 0);
        step(1, 6'b100101, 1, 0);
        step(1, 6'b101000, 0, 0);
        checks++;
        if ({stage_valid, bubble_cnt} !== {3'b101, 16'd1}) begin
            errors++; $display("FAIL stall_valid_cnt: got %b %0d expected 101 1", stage_valid, bubble_cnt);
        end
        checks++;
        if ({id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb} !== {8'b01010000, 2'b00, 3'b000, 2'b10}) begin
            errors++; $display("FAIL stall_bundles: got %b %b %b %b expected 01010000 00 000 10",
                               id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 6'b0, 0, 0);
            checks++;
            if (dut_vec !== mdl_vec()) begin
                errors++; $display("FAIL stall_drain%0d: got %h expected %h", i, dut_vec, mdl_vec());
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(1, 6'b000011, 0, 0);
        step(1, 6'b100100, 0, 0);
        step(0, 6'b000000, 0, 1);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb, stage_valid} !==
            {2'b00, 3'b000, 8'h00, 2'b00, 3'b000, 2'b10, 3'b100}) begin
            errors++; $display("FAIL flush_stages: got %h expected mem_wb_wb=10 valid=100 rest 0", dut_vec);
        end
        step(1, 6'b000001, 1, 1);
        checks++;
        if ({bubble_cnt, stage_valid} !== {16'd0, 3'b000}) begin
            errors++; $display("FAIL flush_stall_cnt: got cnt %0d valid %b expected 0 000", bubble_cnt, stage_valid);
        end
        checks++;
        if (dut_vec !== mdl_vec()) begin
            errors++; $display("FAIL flush_vec: got %h expected %h", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_saturate();
        int exp2 [5];
        exp2 = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 6'b000001, 1, 0);
            checks++;
            if (cnt2 !== 2'(exp2[i]) || bubble_cnt !== 16'(i + 1)) begin
                errors++; $display("FAIL saturate%0d: got %0d/%0d expected %0d/%0d",
                                   i, cnt2, bubble_cnt, exp2[i], i + 1);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1, 6'b111111, 0, 0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        checks++;
        if ({ill, stage_valid[0]} !== 2'b10) begin
            errors++; $display("FAIL illegal_trap: got ill=%b v0=%b expected 1 0", ill, stage_valid[0]);
        end
`else
        checks++;
        if ({stage_valid[0], id_ex_wb, id_ex_m, id_ex_ex} !== 14'b1_00_000_00000000) begin
            errors++; $display("FAIL illegal_pass: got v0=%b bundles %h expected 1 0",
                               stage_valid[0], {id_ex_wb, id_ex_m, id_ex_ex});
        end
`endif
        step(1, 6'b100100, 0, 0);
        checks++;
        if (dut_vec !== mdl_vec()) begin
            errors++; $display("FAIL illegal_sticky: got %h expected %h", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [11];
        logic [5:0] op;
        ops = '{6'b100100, 6'b100101, 6'b000001, 6'b000011, 6'b000101, 6'b000110,
                6'b100000, 6'b100001, 6'b101000, 6'b101001, 6'b101010};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 10)] : 6'($urandom);
            step($urandom_range(0, 3) != 0, op,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            checks++;
            if (dut_vec !== mdl_vec()) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, dut_vec, mdl_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; opcode = '0; stall = 0; flush = 0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 42'd0) begin
            errors++; $display("FAIL reset_initial: got %h expected %h", dut_vec, 42'd0);
        end
        rst = 1'b0;
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_saturate();
        test_random();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
